// File: rtl/board_state_ctrl_pkg.sv
// Shared cell encodings, state encodings and position limits for the tic-tac-toe board controller.
package tic_tac_toe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] POS_MIN = 4'd1;
  localparam logic [3:0] POS_MAX = 4'd9;

  // Player 0 places X, player 1 places O.
  function automatic logic [1:0] player_mark(input logic player);
    return player ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// Move request handshake between the move source (master) and the board controller (slave).
interface board_state_ctrl_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;

  modport master (output move_valid, output move_pos, input  move_ready);
  modport slave  (input  move_valid, input  move_pos, output move_ready);
endinterface

// File: rtl/board_state_ctrl_cell_index_decode.sv
// Maps a 1..9 cell index to a one-hot cell enable; out-of-range indices give no enable.
module cell_index_decode
  import tic_tac_toe_pkg::*;
(
  input  logic [3:0] pos,
  output logic [8:0] onehot,
  output logic       in_range
);

  always_comb begin
    in_range = (pos >= POS_MIN) && (pos <= POS_MAX);
    onehot   = '0;
    for (int i = 0; i < 9; i++) begin
      onehot[i] = in_range && (pos == 4'(i + 1));
    end
  end

endmodule

// File: rtl/board_state_ctrl.sv
// Tic-tac-toe board controller: accepts moves, validates them, commits legal ones
// to a registered 3x3 board and freezes once the downstream detectors report game over.
module board_state_ctrl
  import tic_tac_toe_pkg::*;
#(
  parameter logic FIRST_PLAYER  = 1'b0,
  parameter int   SETTLE_CYCLES = 1
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  board_state_ctrl_if.slave   move_if,
  input  logic                game_over,
  output logic [1:0]          pos1,
  output logic [1:0]          pos2,
  output logic [1:0]          pos3,
  output logic [1:0]          pos4,
  output logic [1:0]          pos5,
  output logic [1:0]          pos6,
  output logic [1:0]          pos7,
  output logic [1:0]          pos8,
  output logic [1:0]          pos9,
  output logic                cur_player,
  output logic [3:0]          move_count,
  output logic                move_accepted,
  output logic                illegal_move,
  output logic                done
);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [3:0] pend_pos;
  logic [1:0] board [9];
  logic [1:0] settle_cnt;
  logic [8:0] pend_onehot;
  logic       pend_in_range;
  logic       target_busy;
  logic       move_legal;
  logic       accept;
  logic       settle_last;

  cell_index_decode u_decode (
    .pos      (pend_pos),
    .onehot   (pend_onehot),
    .in_range (pend_in_range)
  );

  assign accept      = (state == IDLE) && move_if.move_valid && move_if.move_ready;
  assign settle_last = (settle_cnt == 2'(SETTLE_CYCLES - 1));
  assign move_legal  = pend_in_range && !target_busy;

  always_comb begin
    target_busy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pend_onehot[i] && (board[i] != CELL_EMPTY)) target_busy = 1'b1;
    end
  end

  // new_game overrides every transition, including a move already in flight.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CHECK;
      CHECK:   state_next = move_legal ? WRITE : IDLE;
      WRITE:   state_next = SETTLE;
      SETTLE:  if (settle_last) state_next = game_over ? DONE : IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (new_game) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pend_pos           <= '0;
      settle_cnt         <= '0;
      cur_player         <= FIRST_PLAYER;
      move_count         <= '0;
      move_accepted      <= 1'b0;
      illegal_move       <= 1'b0;
      done               <= 1'b0;
      move_if.move_ready <= 1'b1;
      for (int i = 0; i < 9; i++) board[i] <= CELL_EMPTY;
    end else begin
      state              <= state_next;
      move_if.move_ready <= (state_next == IDLE);
      done               <= (state_next == DONE);
      move_accepted      <= 1'b0;
      illegal_move       <= 1'b0;
      if (new_game) begin
        settle_cnt <= '0;
        cur_player <= FIRST_PLAYER;
        move_count <= '0;
        for (int i = 0; i < 9; i++) board[i] <= CELL_EMPTY;
      end else begin
        case (state)
          IDLE: begin
            if (accept) pend_pos <= move_if.move_pos;
          end
          CHECK: begin
            settle_cnt <= '0;
            if (!move_legal) illegal_move <= 1'b1;
          end
          WRITE: begin
            for (int i = 0; i < 9; i++) begin
              if (pend_onehot[i]) board[i] <= player_mark(cur_player);
            end
            cur_player    <= ~cur_player;
            move_accepted <= 1'b1;
            settle_cnt    <= '0;
            if (move_count != 4'd9) move_count <= move_count + 4'd1;
          end
          SETTLE: begin
            if (!settle_last) settle_cnt <= settle_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench for board_state_ctrl: directed scenarios plus randomized games
// compared against a simple game-rules model.
module tb_board_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       game_over;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       cur_player;
  logic [3:0] move_count;
  logic       move_accepted, illegal_move, done;
  logic       use_nospace = 1'b0;
  logic       force_go = 1'b0;

  board_state_ctrl_if bif ();

  always #5 clk = ~clk;

  // Stand-in for the downstream detectors: either "board full" or a forced value.
  assign game_over = use_nospace ? ((pos1 != 0) && (pos2 != 0) && (pos3 != 0) &&
                                    (pos4 != 0) && (pos5 != 0) && (pos6 != 0) &&
                                    (pos7 != 0) && (pos8 != 0) && (pos9 != 0))
                                 : force_go;

  board_state_ctrl #(.FIRST_PLAYER(1'b0), .SETTLE_CYCLES(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_game      (new_game),
    .move_if       (bif),
    .game_over     (game_over),
    .pos1          (pos1),
    .pos2          (pos2),
    .pos3          (pos3),
    .pos4          (pos4),
    .pos5          (pos5),
    .pos6          (pos6),
    .pos7          (pos7),
    .pos8          (pos8),
    .pos9          (pos9),
    .cur_player    (cur_player),
    .move_count    (move_count),
    .move_accepted (move_accepted),
    .illegal_move  (illegal_move),
    .done          (done)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  int mdl_cells [9];
  bit mdl_player;
  int mdl_count;

  function automatic logic [17:0] dut_board();
    return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  endfunction

  function automatic logic [17:0] mdl_board();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mdl_cells[i]);
    return b;
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < 9; i++) mdl_cells[i] = 0;
    mdl_player = 1'b0;
    mdl_count  = 0;
  endfunction

  // Game rules: a move is legal when it names cell 1..9 and that cell is empty.
  function automatic bit mdl_move(input int p);
    if (p < 1 || p > 9) return 1'b0;
    if (mdl_cells[p-1] != 0) return 1'b0;
    mdl_cells[p-1] = mdl_player ? 2 : 1;
    mdl_player     = ~mdl_player;
    mdl_count      = mdl_count + 1;
    return 1'b1;
  endfunction

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    mdl_clear();
  endtask

  // Presents one move and counts the pulses until the block is ready again or frozen.
  task automatic issue_move(input logic [3:0] pos, output int acc, output int ill, output bit to);
    int n;
    to  = 1'b0;
    acc = 0;
    ill = 0;
    n   = 0;
    while (!bif.move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bif.move_ready) begin
      to = 1'b1;
      return;
    end
    bif.move_valid = 1'b1;
    bif.move_pos   = pos;
    @(negedge clk);
    bif.move_valid = 1'b0;
    n = 0;
    while (n < 12) begin
      if (move_accepted) acc++;
      if (illegal_move) ill++;
      if (bif.move_ready || done) break;
      @(negedge clk);
      n++;
    end
    if (n >= 12) to = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mdl_clear();
    checks_total++;
    if (dut_board() !== 18'd0 || move_count !== 4'd0 || cur_player !== 1'b0)
      $display("[TB] FAIL reset_state: board=%h count=%0d player=%0b required board=0 count=0 player=0",
               dut_board(), move_count, cur_player);
    else checks_passed++;
    checks_total++;
    if (bif.move_ready !== 1'b1 || done !== 1'b0)
      $display("[TB] FAIL reset_ready: ready=%0b done=%0b required ready=1 done=0", bif.move_ready, done);
    else checks_passed++;

    // Reset asserted while the controller is in WRITE for a move to cell 7.
    bif.move_valid = 1'b1;
    bif.move_pos   = 4'd7;
    @(negedge clk);
    bif.move_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (dut_board() !== 18'd0 || move_count !== 4'd0 || cur_player !== 1'b0 || move_accepted !== 1'b0)
      $display("[TB] FAIL reset_mid_write: board=%h count=%0d player=%0b acc=%0b required all zero",
               dut_board(), move_count, cur_player, move_accepted);
    else checks_passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks_total++;
    if (bif.move_ready !== 1'b1 || dut_board() !== 18'd0)
      $display("[TB] FAIL reset_release: ready=%0b board=%h required ready=1 board=0", bif.move_ready, dut_board());
    else checks_passed++;
  endtask

  task automatic test_legal_sequence();
    int seq [3] = '{5, 1, 9};
    int acc, ill;
    bit to;
    do_new_game();
    foreach (seq[k]) begin
      issue_move(4'(seq[k]), acc, ill, to);
      void'(mdl_move(seq[k]));
      checks_total++;
      if (to || acc !== 1 || ill !== 0)
        $display("[TB] FAIL legal_pulse pos%0d: acc=%0d ill=%0d timeout=%0b required acc=1 ill=0",
                 seq[k], acc, ill, to);
      else checks_passed++;
    end
    checks_total++;
    if (pos5 !== 2'b01 || pos1 !== 2'b10 || pos9 !== 2'b01 || dut_board() !== mdl_board())
      $display("[TB] FAIL legal_board: board=%h required %h", dut_board(), mdl_board());
    else checks_passed++;
    checks_total++;
    if (move_count !== 4'd3 || cur_player !== 1'b1)
      $display("[TB] FAIL legal_counters: count=%0d player=%0b required count=3 player=1", move_count, cur_player);
    else checks_passed++;
  endtask

  task automatic test_illegal_moves();
    int seq [3] = '{0, 12, 5};
    int acc, ill;
    bit to;
    foreach (seq[k]) begin
      issue_move(4'(seq[k]), acc, ill, to);
      void'(mdl_move(seq[k]));
      checks_total++;
      if (to || acc !== 0 || ill !== 1)
        $display("[TB] FAIL illegal_pulse pos%0d: acc=%0d ill=%0d timeout=%0b required acc=0 ill=1",
                 seq[k], acc, ill, to);
      else checks_passed++;
    end
    checks_total++;
    if (dut_board() !== mdl_board() || move_count !== 4'd3 || cur_player !== 1'b1)
      $display("[TB] FAIL illegal_unchanged: board=%h count=%0d player=%0b required board=%h count=3 player=1",
               dut_board(), move_count, cur_player, mdl_board());
    else checks_passed++;
  endtask

  task automatic test_full_board();
    int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int acc, ill, pulses;
    bit to;
    do_new_game();
    use_nospace = 1'b1;
    foreach (seq[k]) begin
      issue_move(4'(seq[k]), acc, ill, to);
      void'(mdl_move(seq[k]));
      checks_total++;
      if (to || acc !== 1 || ill !== 0)
        $display("[TB] FAIL full_pulse move%0d: acc=%0d ill=%0d timeout=%0b required acc=1 ill=0",
                 k + 1, acc, ill, to);
      else checks_passed++;
    end
    checks_total++;
    if (dut_board() !== mdl_board() || move_count !== 4'd9)
      $display("[TB] FAIL full_board: board=%h count=%0d required %h count=9", dut_board(), move_count, mdl_board());
    else checks_passed++;
    checks_total++;
    if (done !== 1'b1 || bif.move_ready !== 1'b0)
      $display("[TB] FAIL full_frozen: done=%0b ready=%0b required done=1 ready=0", done, bif.move_ready);
    else checks_passed++;
    // A tenth request is held for several cycles and must be ignored.
    pulses = 0;
    bif.move_valid = 1'b1;
    bif.move_pos   = 4'd3;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(move_accepted) + int'(illegal_move);
    end
    bif.move_valid = 1'b0;
    checks_total++;
    if (pulses !== 0 || done !== 1'b1 || dut_board() !== mdl_board())
      $display("[TB] FAIL full_tenth: pulses=%0d done=%0b required pulses=0 done=1", pulses, done);
    else checks_passed++;
    use_nospace = 1'b0;
  endtask

  task automatic test_win_freeze();
    int seq [5] = '{1, 4, 2, 5, 3};
    int acc, ill;
    bit to;
    do_new_game();
    force_go = 1'b1;
    repeat (3) @(negedge clk);
    checks_total++;
    if (done !== 1'b0 || bif.move_ready !== 1'b1)
      $display("[TB] FAIL go_outside_settle: done=%0b ready=%0b required done=0 ready=1", done, bif.move_ready);
    else checks_passed++;
    force_go = 1'b0;
    foreach (seq[k]) begin
      if (k == 4) force_go = 1'b1;
      issue_move(4'(seq[k]), acc, ill, to);
      void'(mdl_move(seq[k]));
      checks_total++;
      if (to || acc !== 1 || ill !== 0)
        $display("[TB] FAIL win_pulse move%0d: acc=%0d ill=%0d timeout=%0b required acc=1 ill=0",
                 k + 1, acc, ill, to);
      else checks_passed++;
    end
    checks_total++;
    if (done !== 1'b1 || bif.move_ready !== 1'b0 || move_count !== 4'd5 || dut_board() !== mdl_board())
      $display("[TB] FAIL win_frozen: done=%0b ready=%0b count=%0d required done=1 ready=0 count=5",
               done, bif.move_ready, move_count);
    else checks_passed++;
    force_go = 1'b0;
    do_new_game();
    checks_total++;
    if (dut_board() !== 18'd0 || done !== 1'b0 || bif.move_ready !== 1'b1 || move_count !== 4'd0 || cur_player !== 1'b0)
      $display("[TB] FAIL win_new_game: board=%h done=%0b ready=%0b count=%0d player=%0b required cleared idle",
               dut_board(), done, bif.move_ready, move_count, cur_player);
    else checks_passed++;
  endtask

  task automatic test_contention();
    int pulses;
    do_new_game();
    new_game       = 1'b1;
    bif.move_valid = 1'b1;
    bif.move_pos   = 4'd3;
    @(negedge clk);
    new_game       = 1'b0;
    bif.move_valid = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(move_accepted) + int'(illegal_move);
    end
    checks_total++;
    if (pos3 !== 2'b00 || move_count !== 4'd0 || pulses !== 0 || bif.move_ready !== 1'b1)
      $display("[TB] FAIL contention: pos3=%0b count=%0d pulses=%0d ready=%0b required pos3=0 count=0 pulses=0 ready=1",
               pos3, move_count, pulses, bif.move_ready);
    else checks_passed++;

    // new_game while a move to cell 6 sits in CHECK discards it silently.
    bif.move_valid = 1'b1;
    bif.move_pos   = 4'd6;
    @(negedge clk);
    bif.move_valid = 1'b0;
    new_game       = 1'b1;
    @(negedge clk);
    new_game       = 1'b0;
    pulses = 0;
    repeat (4) begin
      pulses += int'(move_accepted) + int'(illegal_move);
      @(negedge clk);
    end
    checks_total++;
    if (dut_board() !== 18'd0 || move_count !== 4'd0 || pulses !== 0 || bif.move_ready !== 1'b1)
      $display("[TB] FAIL new_game_mid_check: board=%h count=%0d pulses=%0d ready=%0b required cleared, no pulse",
               dut_board(), move_count, pulses, bif.move_ready);
    else checks_passed++;
    mdl_clear();
  endtask

  task automatic test_random_games();
    int acc, ill, p, tries;
    bit to, legal;
    for (int g = 0; g < 4; g++) begin
      do_new_game();
      use_nospace = 1'b1;
      tries = 0;
      while (mdl_count < 9 && tries < 40) begin
        p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 15));
        issue_move(4'(p), acc, ill, to);
        legal = mdl_move(p);
        checks_total++;
        if (to || acc !== int'(legal) || ill !== int'(!legal))
          $display("[TB] FAIL rand_outcome g%0d pos%0d: acc=%0d ill=%0d timeout=%0b required acc=%0d ill=%0d",
                   g, p, acc, ill, to, int'(legal), int'(!legal));
        else checks_passed++;
        checks_total++;
        if (dut_board() !== mdl_board() || move_count !== 4'(mdl_count) || cur_player !== mdl_player)
          $display("[TB] FAIL rand_state g%0d: board=%h count=%0d player=%0b required board=%h count=%0d player=%0b",
                   g, dut_board(), move_count, cur_player, mdl_board(), mdl_count, mdl_player);
        else checks_passed++;
        tries++;
      end
      checks_total++;
      if (done !== (mdl_count == 9))
        $display("[TB] FAIL rand_done g%0d: done=%0b required %0b", g, done, mdl_count == 9);
      else checks_passed++;
      use_nospace = 1'b0;
    end
  endtask

  initial begin
    bif.move_valid = 1'b0;
    bif.move_pos   = 4'd0;
    @(negedge clk);
    test_reset();
    test_legal_sequence();
    test_illegal_moves();
    test_full_board();
    test_win_freeze();
    test_contention();
    test_random_games();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
